// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sram_ctrl
//  Description : Single-port controller for a 512K x 16 asynchronous SRAM.
//                Accepts word read/write requests on a valid/ready handshake
//                and drives registered ADR/DAT/RAMCS/RAMOE/RAMWE with a fixed
//                strobe length, a read turnaround cycle and a write hold cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_ctrl #(
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] ADR,
  output logic [DATA_W-1:0] DAT_out,
  output logic              DAT_oe,
  input  logic [DATA_W-1:0] DAT_in,
  output logic              RAMCS,
  output logic              RAMOE,
  output logic              RAMWE
);

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_READ  = 3'd1;
  localparam logic [2:0] c_ST_WRITE = 3'd2;
  localparam logic [2:0] c_ST_WHOLD = 3'd3;
  localparam logic [2:0] c_ST_TURN  = 3'd4;

  // Counter is loaded with W-1 so the strobe lasts exactly W cycles.
  localparam logic [3:0] c_WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [3:0]        r_cnt;
  logic              r_cs;
  logic              r_oe;
  logic              r_we;
  logic              r_dat_oe;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic [ADDR_W-1:0] r_adr;
  logic [DATA_W-1:0] r_dat_out;

  logic w_accept;
  logic w_cnt_zero;
  logic w_cs_nxt;
  logic w_oe_nxt;
  logic w_we_nxt;
  logic w_dat_oe_nxt;
  logic w_rsp_valid_nxt;

  // Ready is held low while reset is asserted, even though the state is IDLE.
  assign req_ready  = (r_state == c_ST_IDLE) && rst_n;
  assign w_accept   = req_valid && req_ready;
  assign w_cnt_zero = (r_cnt == 4'd0);

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign ADR       = r_adr;
  assign DAT_out   = r_dat_out;
  assign DAT_oe    = r_dat_oe;
  assign RAMCS     = r_cs;
  assign RAMOE     = r_oe;
  assign RAMWE     = r_we;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode: strobe phases end when the wait counter hits zero.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:  if (w_accept) w_state_nxt = req_we ? c_ST_WRITE : c_ST_READ;
      c_ST_READ:  if (w_cnt_zero) w_state_nxt = c_ST_TURN;
      c_ST_WRITE: if (w_cnt_zero) w_state_nxt = c_ST_WHOLD;
      c_ST_WHOLD: w_state_nxt = c_ST_IDLE;
      c_ST_TURN:  w_state_nxt = c_ST_IDLE;
      default:    w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Output decode from the next state, so the registered pins line up with it.
  always_comb begin
    w_cs_nxt        = 1'b1;
    w_oe_nxt        = 1'b1;
    w_we_nxt        = 1'b1;
    w_dat_oe_nxt    = 1'b0;
    w_rsp_valid_nxt = 1'b0;
    case (w_state_nxt)
      c_ST_READ: begin
        w_cs_nxt = 1'b0;
        w_oe_nxt = 1'b0;
      end
      c_ST_WRITE: begin
        w_cs_nxt     = 1'b0;
        w_we_nxt     = 1'b0;
        w_dat_oe_nxt = 1'b1;
      end
      c_ST_WHOLD: begin
        w_cs_nxt     = 1'b0;
        w_dat_oe_nxt = 1'b1;
      end
      c_ST_TURN: w_rsp_valid_nxt = 1'b1;
      default: ;
    endcase
  end

  // Registered pins, wait counter, latched request fields and read capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cs        <= 1'b1;
      r_oe        <= 1'b1;
      r_we        <= 1'b1;
      r_dat_oe    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_adr       <= '0;
      r_dat_out   <= '0;
      r_cnt       <= 4'd0;
    end else begin
      r_cs        <= w_cs_nxt;
      r_oe        <= w_oe_nxt;
      r_we        <= w_we_nxt;
      r_dat_oe    <= w_dat_oe_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      if (w_accept) begin
        r_adr     <= req_addr;
        r_dat_out <= req_wdata;
        r_cnt     <= c_WAIT_LOAD;
      end else if (((r_state == c_ST_READ) || (r_state == c_ST_WRITE)) && !w_cnt_zero) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if ((r_state == c_ST_READ) && w_cnt_zero) begin
        r_rsp_rdata <= DAT_in;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/sram_ctrl.md
# sram_ctrl

Single-port controller for the board's 512K x 16 asynchronous SRAM. It accepts word read/write requests on a valid/ready handshake and generates registered ADR, DAT, RAMCS, RAMOE and RAMWE timing with a fixed access length and bus turnaround. It sits between on-chip logic and the chip-level SRAM pins, replacing the constant idle tie-offs. Tristating of the data bus is left to the top level via DAT_oe.

## Interface

Parameters:
- ADDR_W, 19, SRAM address width.
- DATA_W, 16, SRAM data width.
- WAIT_CYCLES, 2, clk cycles each strobe (OE or WE) is held low; legal range 1..15. 2 covers a 10 ns part at 100 MHz.

Ports:
- Clocking is decided: one clock; reset is synchronous and active-low.
- clk  in  1  100 MHz system clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present; must be held with its fields until accepted.
- req_ready  out  1  controller idle; a request is accepted on an edge where valid and ready are both 1.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle pulse; rsp_rdata is valid. Reads only.
- rsp_rdata  out  DATA_W  read data; holds its value until the next read response.
- ADR  out  ADDR_W  SRAM address.
- DAT_out  out  DATA_W  data driven to the SRAM.
- DAT_oe  out  1  1 = top level drives DAT_out onto the pins.
- DAT_in  in  DATA_W  data sampled from the pins.
- RAMCS, RAMOE, RAMWE  out  1 each  active-low SRAM strobes.

## Operation

- State machine states: IDLE, READ, WRITE, WHOLD, TURN.
- IDLE:
  - req_ready = 1 when rst_n = 1, otherwise 0.
  - All strobes are high and DAT_oe = 0.
  - On acceptance, latch addr, wdata and we, load the wait counter with WAIT_CYCLES-1, and go to READ or WRITE.
- READ:
  - RAMCS = 0, RAMOE = 0, RAMWE = 1, DAT_oe = 0.
  - When the counter reaches 0, capture DAT_in into rsp_rdata on that edge and go to TURN. Otherwise decrement the counter.
- TURN: one cycle with all strobes high and DAT_oe = 0. rsp_valid = 1 in this cycle. Then go to IDLE.
- WRITE:
  - RAMCS = 0, RAMWE = 0, RAMOE = 1, DAT_oe = 1, DAT_out = latched wdata.
  - When the counter reaches 0, go to WHOLD.
- WHOLD: one data-hold cycle with RAMWE = 1, RAMCS = 0, DAT_oe = 1, and DAT_out and ADR unchanged. Then go to IDLE.
- All pin outputs and rsp_* are registered, so there is no combinational path from req_* to the pins.
- ADR and DAT_out keep their last values between accesses. They update only on acceptance.
- Invariant: RAMOE = 0 and DAT_oe = 1 are never true in the same cycle.
- Invariant: RAMWE = 0 only when RAMCS = 0.
- Requests presented while busy are not accepted (req_ready = 0). The requester holds them.
- The wait counter is 4 bits. No other arithmetic is needed.

## Timing

- Acceptance edge ends cycle T. Let W = WAIT_CYCLES.
- Read:
  - ADR and RAMCS = 0, RAMOE = 0 are valid in cycles T+1..T+W.
  - DAT_in is sampled at the end of T+W.
  - rsp_valid = 1 in T+W+1.
  - req_ready = 1 in T+W+2.
  - Occupancy is W+2 cycles.
- Write:
  - RAMWE = 0 in T+1..T+W.
  - Hold cycle at T+W+1.
  - req_ready = 1 in T+W+2.
  - Occupancy is W+2 cycles.
- Maximum back-to-back rate is one access per W+2 cycles, with no gap between TURN/WHOLD→IDLE and the next acceptance.
- Reset values, applied at the first edge with rst_n = 0:
  - state = IDLE.
  - RAMCS = RAMOE = RAMWE = 1, DAT_oe = 0.
  - ADR = 0, DAT_out = 0.
  - rsp_valid = 0, rsp_rdata = 0.
  - Wait counter = 0.
- Reset mid-operation: the transaction is abandoned, strobes go high at that edge, and no rsp_valid is produced. req_ready rises in the first cycle with rst_n = 1.
- Address wrap: none. The address is used verbatim; 0x7FFFF is a legal last word.

## Test plan

- Reset: hold rst_n = 0 for 3 cycles with req_valid = 1 → RAMCS, RAMOE, RAMWE all 1, DAT_oe = 0, req_ready = 0, no strobe activity; req_ready = 1 in the first cycle after release.
- Write with W = 2, addr 0x12345, data 0xA5C3:
  - RAMCS = 0 for cycles T+1..T+3.
  - RAMWE = 0 for T+1..T+2 only.
  - DAT_oe = 1 for T+1..T+3, with ADR = 0x12345 and DAT_out = 0xA5C3 throughout.
  - req_ready = 1 at T+4.
- Read-back of 0x12345 against a behavioural SRAM model → RAMOE = 0 for exactly 2 cycles, rsp_valid pulses once at T+3 with rsp_rdata = 0xA5C3, DAT_oe = 0 throughout.
- Back-to-back stream: req_valid held high, alternating write/read at addresses 0x00000 and 0x7FFFF with data 0xFFFF and 0x0001 → one acceptance every 4 cycles, read data matches the written data, and no cycle has RAMOE = 0 with DAT_oe = 1.
- Reset at T+1 of a write → RAMWE and RAMCS = 1 from the next edge, no rsp_valid, model memory unchanged at that address if the check is done with WE strobe-edge semantics.
- WAIT_CYCLES = 1 build: read of a preloaded 0x5A5A → RAMOE low for 1 cycle, rsp_valid at T+2, req_ready at T+3.
